// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register scoreboard.
package reg_scoreboard_pkg;

   localparam int REG_IDX_W    = 5;   // architectural register index width
   localparam int BUNDLE_W     = 3;   // issue slots per bundle
   localparam int CNT_W        = 2;   // per-register countdown width
   localparam int DEF_LOAD_LAT = 2;   // default load-use latency
   localparam int DEF_ALU_LAT  = 1;   // default ALU-use latency

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [CNT_W-1:0]     cnt_t;

   // The issue edge itself consumes the first latency cycle, so an entry is
   // loaded with LAT-1 and a latency of 1 leaves no hazard at all.
   function automatic cnt_t issue_cnt(input int lat);
      return cnt_t'(lat - 1);
   endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// ID-stage bundle / hazard-control bundle between decode and the scoreboard.
interface reg_scoreboard_if;
   import reg_scoreboard_pkg::*;

   reg_idx_t            src1;
   reg_idx_t            src2;
   reg_idx_t            src3;
   logic                issue;
   logic [BUNDLE_W-1:0] slot_wr;
   logic [BUNDLE_W-1:0] slot_ld;
   reg_idx_t            slot_dst0;
   reg_idx_t            slot_dst1;
   reg_idx_t            slot_dst2;
   logic                flush;
   logic                stall;
   logic                pc_write;
   logic                if_id_write;
   logic                id_ex_bubble;

   // Decode side: presents the bundle, obeys the hazard controls.
   modport master (
      output src1, src2, src3, issue, slot_wr, slot_ld,
             slot_dst0, slot_dst1, slot_dst2, flush,
      input  stall, pc_write, if_id_write, id_ex_bubble
   );

   // Scoreboard side.
   modport slave (
      input  src1, src2, src3, issue, slot_wr, slot_ld,
             slot_dst0, slot_dst1, slot_dst2, flush,
      output stall, pc_write, if_id_write, id_ex_bubble
   );

endinterface

// File: rtl/reg_scoreboard_sb_entry.sv
// One scoreboard entry: countdown of cycles until the register is usable.
// Build option SB_FWD_EN: also remember whether the producer was a load, so
// that only load-pending registers raise a hazard.
module sb_entry
   import reg_scoreboard_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load_en,    // producer issued to this register this cycle
   input  cnt_t load_val,   // countdown to start from
`ifdef SB_FWD_EN
   input  logic load_ld,    // producer is a load
`endif
   output logic hazard      // consumer must wait on this register
);

   cnt_t cnt_d, cnt_q;
`ifdef SB_FWD_EN
   logic ld_d, ld_q;
`endif

   // Next count: a new producer overrides, otherwise count down to zero.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      cnt_d = cnt_q;
      if (load_en) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
`ifdef SB_FWD_EN
      ld_d = ld_q;
      if (load_en) begin
         ld_d = load_ld;
      end
`endif
   end

   // Entry state with synchronous clear.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so all flops sample the pre-edge values.
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

`ifdef SB_FWD_EN
   // Producer-type flag; only meaningful while the count is nonzero.
   always_ff @(posedge clk) begin
      if (rst) begin
         ld_q <= 1'b0;
      end else begin
         ld_q <= ld_d;
      end
   end

   assign hazard = (cnt_q != '0) && ld_q;
`else
   assign hazard = (cnt_q != '0);
`endif

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard for a 3-slot in-order issue stage.
// Tracks per-register result latency and stalls a dependent bundle in ID.
// Build option SB_FWD_EN: ALU results are forwarded, only loads cause stalls.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int NREG     = 32,
   parameter int LOAD_LAT = DEF_LOAD_LAT,
   parameter int ALU_LAT  = DEF_ALU_LAT
) (
   input  logic            clk,
   input  logic            rst,
   reg_scoreboard_if.slave sb
);

   localparam cnt_t LOAD_CNT = issue_cnt(LOAD_LAT);
   localparam cnt_t ALU_CNT  = issue_cnt(ALU_LAT);

   reg_idx_t        src [3];
   reg_idx_t        dst [BUNDLE_W];
   logic [NREG-1:0] hazard;
   logic            stall;
   logic            accept;
   logic [NREG-1:1] ld_en;
   cnt_t            ld_val [NREG-1:1];
   cnt_t            slot_cnt;
`ifdef SB_FWD_EN
   logic [NREG-1:1] ld_flag;
`endif

   assign src[0] = sb.src1;
   assign src[1] = sb.src2;
   assign src[2] = sb.src3;
   assign dst[0] = sb.slot_dst0;
   assign dst[1] = sb.slot_dst1;
   assign dst[2] = sb.slot_dst2;

   // Stall when any nonzero source still has a hazard outstanding.
   always_comb begin
      stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (src[i] != '0 && int'(src[i]) < NREG && hazard[src[i]]) begin
            stall = 1'b1;
         end
      end
   end

   // A flushed or stalled bundle never writes the scoreboard.
   assign accept = sb.issue && !stall && !sb.flush;

   // Per-register load requests from the issuing bundle; same-dst slots keep the larger latency.
   always_comb begin
      ld_en    = '0;
      slot_cnt = '0;
      for (int r = 1; r < NREG; r++) begin
         ld_val[r] = '0;
      end
`ifdef SB_FWD_EN
      ld_flag = '0;
`endif
      for (int s = 0; s < BUNDLE_W; s++) begin
         slot_cnt = sb.slot_ld[s] ? LOAD_CNT : ALU_CNT;
         if (accept && sb.slot_wr[s] && dst[s] != '0 && int'(dst[s]) < NREG) begin
            ld_en[dst[s]] = 1'b1;
            if (slot_cnt > ld_val[dst[s]]) begin
               ld_val[dst[s]] = slot_cnt;
            end
`ifdef SB_FWD_EN
            // Conservative when slots tie: any load makes the entry load-pending.
            ld_flag[dst[s]] = ld_flag[dst[s]] | sb.slot_ld[s];
`endif
         end
      end
   end

   // Register 0 is hardwired zero and never tracked.
   assign hazard[0] = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_entry
      sb_entry u_entry (
         .clk      (clk),
         .rst      (rst),
         .load_en  (ld_en[r]),
         .load_val (ld_val[r]),
`ifdef SB_FWD_EN
         .load_ld  (ld_flag[r]),
`endif
         .hazard   (hazard[r])
      );
   end

   assign sb.stall        = stall;
   assign sb.pc_write     = ~stall;
   assign sb.if_id_write  = ~stall;
   assign sb.id_ex_bubble = stall | sb.flush;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: dut_a uses default latencies
// (LOAD_LAT=2, ALU_LAT=1), dut_b uses LOAD_LAT=3, ALU_LAT=2. Both see
// identical stimulus; expectations follow the SB_FWD_EN build option.
module tb_reg_scoreboard;

`ifdef SB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   reg_scoreboard_if if_a ();
   reg_scoreboard_if if_b ();

   reg_scoreboard #(.NREG(32), .LOAD_LAT(2), .ALU_LAT(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .sb  (if_a)
   );

   reg_scoreboard #(.NREG(32), .LOAD_LAT(3), .ALU_LAT(2)) dut_b (
      .clk (clk),
      .rst (rst),
      .sb  (if_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Present one bundle to both scoreboards, then let the outputs settle.
   task automatic drive(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3,
                        input logic iss, input logic [2:0] wr, input logic [2:0] ld,
                        input logic [4:0] d0, input logic [4:0] d1, input logic [4:0] d2,
                        input logic fl);
      if_a.src1 = s1;  if_a.src2 = s2;  if_a.src3 = s3;
      if_a.issue = iss; if_a.slot_wr = wr; if_a.slot_ld = ld;
      if_a.slot_dst0 = d0; if_a.slot_dst1 = d1; if_a.slot_dst2 = d2;
      if_a.flush = fl;
      if_b.src1 = s1;  if_b.src2 = s2;  if_b.src3 = s3;
      if_b.issue = iss; if_b.slot_wr = wr; if_b.slot_ld = ld;
      if_b.slot_dst0 = d0; if_b.slot_dst1 = d1; if_b.slot_dst2 = d2;
      if_b.flush = fl;
      #1;
   endtask

   task automatic nop();
      drive(0, 0, 0, 1'b0, 3'b000, 3'b000, 0, 0, 0, 1'b0);
   endtask

   // Advance past the next rising edge, sampling away from it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      nop();
      repeat (3) cyc();
      rst = 1'b0;
      nop();

      // Reset state
      check("rst_a_stall", if_a.stall, 1'b0);
      check("rst_a_pcw", if_a.pc_write, 1'b1);
      check("rst_a_ifid", if_a.if_id_write, 1'b1);
      check("rst_a_bub", if_a.id_ex_bubble, 1'b0);
      check("rst_b_stall", if_b.stall, 1'b0);
      drive(0, 0, 0, 1'b0, 3'b000, 3'b000, 0, 0, 0, 1'b1);
      check("rst_flush_bub", if_a.id_ex_bubble, 1'b1);
      check("rst_flush_pcw", if_a.pc_write, 1'b1);
      cyc();

      // Load r5 then dependent src1=5
      drive(0, 0, 0, 1'b1, 3'b001, 3'b001, 5, 0, 0, 1'b0);
      check("ld5_issue_stall", if_a.stall, 1'b0);
      cyc();
      drive(5, 0, 0, 1'b1, 3'b000, 3'b000, 0, 0, 0, 1'b0);
      check("ld5_a_stall", if_a.stall, 1'b1);
      check("ld5_a_pcw", if_a.pc_write, 1'b0);
      check("ld5_a_ifid", if_a.if_id_write, 1'b0);
      check("ld5_a_bub", if_a.id_ex_bubble, 1'b1);
      check("ld5_b_stall", if_b.stall, 1'b1);
      cyc();
      check("ld5_a_release", if_a.stall, 1'b0);
      check("ld5_a_pcw2", if_a.pc_write, 1'b1);
      check("ld5_a_bub2", if_a.id_ex_bubble, 1'b0);
      check("ld5_b_stall2", if_b.stall, 1'b1);
      cyc();
      check("ld5_b_release", if_b.stall, 1'b0);
      nop();
      cyc();

      // ALU r7 then dependent src2=7
      drive(0, 0, 0, 1'b1, 3'b001, 3'b000, 7, 0, 0, 1'b0);
      cyc();
      drive(0, 7, 0, 1'b1, 3'b000, 3'b000, 0, 0, 0, 1'b0);
      check("alu7_a_stall", if_a.stall, 1'b0);
      check("alu7_b_stall", if_b.stall, FWD ? 1'b0 : 1'b1);
      cyc();
      check("alu7_b_release", if_b.stall, 1'b0);
      nop();
      cyc();

      // Slot0 ALU r9 + slot2 load r9, dependent src3=9
      drive(0, 0, 0, 1'b1, 3'b101, 3'b100, 9, 0, 9, 1'b0);
      cyc();
      drive(0, 0, 9, 1'b1, 3'b000, 3'b000, 0, 0, 0, 1'b0);
      check("max9_a_stall", if_a.stall, 1'b1);
      check("max9_b_stall", if_b.stall, 1'b1);
      cyc();
      check("max9_a_release", if_a.stall, 1'b0);
      check("max9_b_stall2", if_b.stall, 1'b1);
      cyc();
      check("max9_b_release", if_b.stall, 1'b0);
      nop();
      cyc();

      // Slot0 load r11 + slot2 ALU r11: larger latency must win regardless of slot order
      drive(0, 0, 0, 1'b1, 3'b101, 3'b001, 11, 0, 11, 1'b0);
      cyc();
      drive(11, 0, 0, 1'b1, 3'b000, 3'b000, 0, 0, 0, 1'b0);
      check("max11_a_stall", if_a.stall, 1'b1);
      check("max11_b_stall", if_b.stall, 1'b1);
      cyc();
      check("max11_a_release", if_a.stall, 1'b0);
      check("max11_b_stall2", if_b.stall, 1'b1);
      cyc();
      check("max11_b_release", if_b.stall, 1'b0);
      nop();
      cyc();

      // Slot1 load r20, dependent src2=20
      drive(0, 0, 0, 1'b1, 3'b010, 3'b010, 0, 20, 0, 1'b0);
      cyc();
      drive(0, 20, 0, 1'b1, 3'b000, 3'b000, 0, 0, 0, 1'b0);
      check("ld20_a_stall", if_a.stall, 1'b1);
      check("ld20_b_stall", if_b.stall, 1'b1);
      cyc();
      check("ld20_a_release", if_a.stall, 1'b0);
      nop();
      cyc();

      // Writes to r0 are ignored
      drive(0, 0, 0, 1'b1, 3'b011, 3'b001, 0, 0, 0, 1'b0);
      cyc();
      drive(0, 0, 0, 1'b1, 3'b000, 3'b000, 0, 0, 0, 1'b0);
      check("r0_a_stall", if_a.stall, 1'b0);
      check("r0_b_stall", if_b.stall, 1'b0);
      nop();
      cyc();

      // Flushed bundle does not issue its load to r6
      drive(0, 0, 0, 1'b1, 3'b001, 3'b001, 6, 0, 0, 1'b1);
      check("fl6_bub", if_a.id_ex_bubble, 1'b1);
      check("fl6_stall", if_a.stall, 1'b0);
      cyc();
      drive(6, 0, 0, 1'b1, 3'b000, 3'b000, 0, 0, 0, 1'b0);
      check("fl6_a_nostall", if_a.stall, 1'b0);
      check("fl6_b_nostall", if_b.stall, 1'b0);
      nop();
      cyc();

      // Load r4, flush during the dependent stall; counts keep running
      drive(0, 0, 0, 1'b1, 3'b001, 3'b001, 4, 0, 0, 1'b0);
      cyc();
      drive(4, 0, 0, 1'b1, 3'b000, 3'b000, 0, 0, 0, 1'b1);
      check("fl4_a_stall", if_a.stall, 1'b1);
      check("fl4_a_bub", if_a.id_ex_bubble, 1'b1);
      check("fl4_b_stall", if_b.stall, 1'b1);
      cyc();
      drive(4, 0, 0, 1'b1, 3'b000, 3'b000, 0, 0, 0, 1'b0);
      check("fl4_a_release", if_a.stall, 1'b0);
      check("fl4_a_bub2", if_a.id_ex_bubble, 1'b0);
      check("fl4_b_stall2", if_b.stall, 1'b1);
      cyc();
      check("fl4_b_release", if_b.stall, 1'b0);
      nop();
      cyc();

      // ALU r3 then load r3: the new producer overrides the countdown
      drive(0, 0, 0, 1'b1, 3'b001, 3'b000, 3, 0, 0, 1'b0);
      cyc();
      drive(0, 0, 0, 1'b1, 3'b001, 3'b001, 3, 0, 0, 1'b0);
      cyc();
      drive(0, 0, 3, 1'b1, 3'b000, 3'b000, 0, 0, 0, 1'b0);
      check("ovr3_a_stall", if_a.stall, 1'b1);
      check("ovr3_b_stall", if_b.stall, 1'b1);
      cyc();
      check("ovr3_a_release", if_a.stall, 1'b0);
      check("ovr3_b_stall2", if_b.stall, 1'b1);
      nop();
      cyc();
      cyc();

      // Reset while stalled on r12
      drive(0, 0, 0, 1'b1, 3'b001, 3'b001, 12, 0, 0, 1'b0);
      cyc();
      drive(12, 0, 0, 1'b1, 3'b000, 3'b000, 0, 0, 0, 1'b0);
      check("rst12_a_stall", if_a.stall, 1'b1);
      check("rst12_b_stall", if_b.stall, 1'b1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      check("rst12_a_release", if_a.stall, 1'b0);
      check("rst12_a_pcw", if_a.pc_write, 1'b1);
      check("rst12_b_release", if_b.stall, 1'b0);
      cyc();
      check("rst12_b_hold", if_b.stall, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
